// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned INST_BYTES           = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register: async reset to the reset vector, loadable.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  // Hold the next fetch address; only loads when the controller asks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else if (load_en_i) begin
      pc_q <= load_val_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues memory reads, hands words to decode,
// follows redirects and locks up on a misaligned redirect target.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out,
  output logic        misalign_err
);

  localparam logic [31:0] INST_STEP = 32'(INST_BYTES);

  fetch_state_e state_q, state_d;
  logic        instValid_q, instValid_d;
  logic [31:0] instOut_q, instOut_d;
  logic [31:0] instPc_q, instPc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] drainAddr_q, drainAddr_d;
  logic        pcLoadEn;
  logic [31:0] pcLoadVal;
  logic [31:0] pcValue;
  logic        redirectMisaligned;

  fetch_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load_en_i (pcLoadEn),
    .load_val_i(pcLoadVal),
    .pc_o      (pcValue)
  );

  assign redirectMisaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

  // Next-state, pc update and decode-side register updates for every state.
  always_comb begin
    state_d     = state_q;
    instValid_d = instValid_q;
    instOut_d   = instOut_q;
    instPc_d    = instPc_q;
    misalign_d  = misalign_q;
    drainAddr_d = drainAddr_q;
    pcLoadEn    = 1'b0;
    pcLoadVal   = redirect_target;

    if ((state_q != ERR) && redirectMisaligned) begin
      misalign_d  = 1'b1;
      instValid_d = 1'b0;
      state_d     = ERR;
    end else begin
      case (state_q)
        IDLE: begin
          pcLoadEn = redirect_valid;
          state_d  = REQ;
        end
        REQ: begin
          if (redirect_valid) begin
            pcLoadEn = 1'b1;
            if (imem_ack) begin
              state_d = REQ;
            end else begin
              drainAddr_d = pcValue;
              state_d     = DRAIN;
            end
          end else if (imem_ack) begin
            instOut_d   = imem_rdata;
            instPc_d    = pcValue;
            instValid_d = 1'b1;
            pcLoadEn    = 1'b1;
            pcLoadVal   = pcValue + INST_STEP;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            instValid_d = 1'b0;
            pcLoadEn    = 1'b1;
            state_d     = REQ;
          end else if (inst_ready) begin
            instValid_d = 1'b0;
            state_d     = REQ;
          end
        end
        DRAIN: begin
          // A redirect arriving together with the drain ack still updates the
          // target, and the stale request is finished so we move on.
          pcLoadEn = redirect_valid;
          if (imem_ack) begin
            state_d = REQ;
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Register the FSM state and the decode-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      instValid_q <= 1'b0;
      instOut_q   <= 32'h0;
      instPc_q    <= 32'h0;
      misalign_q  <= 1'b0;
      drainAddr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      instValid_q <= instValid_d;
      instOut_q   <= instOut_d;
      instPc_q    <= instPc_d;
      misalign_q  <= misalign_d;
      drainAddr_q <= drainAddr_d;
    end
  end

  assign imem_req     = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr    = (state_q == DRAIN) ? drainAddr_q : pcValue;
  assign inst_valid   = instValid_q;
  assign inst_out     = instOut_q;
  assign inst_pc      = instPc_q;
  assign pc_out       = pcValue;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized handshake run checked against an address-sequence model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid, imem_ack, inst_ready;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, inst_valid, misalign_err;
  logic [31:0] imem_addr, inst_out, inst_pc, pc_out;

  logic        w_redirect_valid, w_imem_ack, w_inst_ready;
  logic [31:0] w_redirect_target, w_imem_rdata;
  logic        w_imem_req, w_inst_valid, w_misalign_err;
  logic [31:0] w_imem_addr, w_inst_out, w_inst_pc, w_pc_out;

  int total = 0;
  int bad   = 0;

  fetch_controller dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .pc_out(pc_out), .misalign_err(misalign_err)
  );

  fetch_controller #(.RESET_VECTOR(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst),
    .redirect_valid(w_redirect_valid), .redirect_target(w_redirect_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
    .inst_out(w_inst_out), .inst_pc(w_inst_pc),
    .pc_out(w_pc_out), .misalign_err(w_misalign_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 0; redirect_target = 0; imem_ack = 0; imem_rdata = 0; inst_ready = 0;
    w_redirect_valid = 0; w_redirect_target = 0; w_imem_ack = 0; w_imem_rdata = 0; w_inst_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc got=%h exp=0", pc_out); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", inst_valid); end
    total++; if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_inst got=%h/%h exp=0/0", inst_out, inst_pc); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err got=%b exp=0", misalign_err); end
    rst = 0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_req got=%b exp=0", imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_basic();
    logic [31:0] expPc, data;
    expPc = 32'h0;
    inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== expPc) begin bad++; $display("[TB] FAIL basic_addr got=%b/%h exp=1/%h", imem_req, imem_addr, expPc); end
      data = $urandom;
      imem_ack = 1; imem_rdata = data;
      tick();
      imem_ack = 0;
      total++; if (inst_valid !== 1'b1 || inst_out !== data || inst_pc !== expPc) begin bad++; $display("[TB] FAIL basic_inst got=%b/%h/%h exp=1/%h/%h", inst_valid, inst_out, inst_pc, data, expPc); end
      total++; if (imem_req !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_hold got=%b/%b exp=0/0", imem_req, misalign_err); end
      tick();
      total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drop got=%b exp=0", inst_valid); end
      expPc = expPc + 32'd4;
    end
    inst_ready = 0;
  endtask

  task automatic test_random_handshake();
    logic [31:0] expPc, data;
    int ackDelay, readyDelay;
    do_reset();
    expPc = 32'h0;
    for (int n = 0; n < 16; n++) begin
      ackDelay   = (n == 0) ? 3 : int'($urandom_range(0, 3));
      readyDelay = (n == 0) ? 2 : int'($urandom_range(0, 2));
      inst_ready = 0;
      for (int k = 0; k < ackDelay; k++) begin
        imem_rdata = $urandom;
        total++; if (imem_req !== 1'b1 || imem_addr !== expPc) begin bad++; $display("[TB] FAIL rnd_wait got=%b/%h exp=1/%h", imem_req, imem_addr, expPc); end
        tick();
      end
      total++; if (imem_req !== 1'b1 || imem_addr !== expPc) begin bad++; $display("[TB] FAIL rnd_req got=%b/%h exp=1/%h", imem_req, imem_addr, expPc); end
      data = $urandom;
      imem_ack = 1; imem_rdata = data;
      tick();
      imem_ack = 0; imem_rdata = $urandom;
      total++; if (inst_valid !== 1'b1 || inst_out !== data || inst_pc !== expPc) begin bad++; $display("[TB] FAIL rnd_inst got=%b/%h/%h exp=1/%h/%h", inst_valid, inst_out, inst_pc, data, expPc); end
      total++; if (pc_out !== expPc + 32'd4) begin bad++; $display("[TB] FAIL rnd_pc got=%h exp=%h", pc_out, expPc + 32'd4); end
      for (int k = 0; k < readyDelay; k++) begin
        tick();
        total++; if (inst_valid !== 1'b1 || inst_out !== data || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rnd_hold got=%b/%h/%b exp=1/%h/0", inst_valid, inst_out, imem_req, data); end
      end
      inst_ready = 1;
      tick();
      inst_ready = 0;
      expPc = expPc + 32'd4;
      total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== expPc) begin bad++; $display("[TB] FAIL rnd_next got=%b/%b/%h exp=0/1/%h", inst_valid, imem_req, imem_addr, expPc); end
    end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] data;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      imem_ack = 1; imem_rdata = $urandom;
      tick();
      imem_ack = 0; inst_ready = 1;
      tick();
      inst_ready = 0;
    end
    redirect_valid = 1; redirect_target = 32'h100;
    tick();
    redirect_valid = 0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || pc_out !== 32'h100) begin bad++; $display("[TB] FAIL drain_enter got=%b/%h/%h exp=1/8/100", imem_req, imem_addr, pc_out); end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL drain_stable got=%h exp=8", imem_addr); end
    end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 0;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL drain_exit got=%b/%b/%h exp=0/1/100", inst_valid, imem_req, imem_addr); end
    data = $urandom;
    imem_ack = 1; imem_rdata = data;
    tick();
    imem_ack = 0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_out !== data) begin bad++; $display("[TB] FAIL drain_inst got=%b/%h/%h exp=1/100/%h", inst_valid, inst_pc, inst_out, data); end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    redirect_valid = 1; redirect_target = 32'h300;
    tick();
    redirect_target = 32'h340;
    tick();
    redirect_valid = 0;
    total++; if (imem_addr !== 32'h104 || pc_out !== 32'h340) begin bad++; $display("[TB] FAIL drain_latest got=%h/%h exp=104/340", imem_addr, pc_out); end
    imem_ack = 1;
    tick();
    imem_ack = 0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h340) begin bad++; $display("[TB] FAIL drain_target got=%b/%h exp=1/340", imem_req, imem_addr); end
    redirect_valid = 1; redirect_target = 32'h500; imem_ack = 1; imem_rdata = $urandom;
    tick();
    redirect_valid = 0; imem_ack = 0;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h500) begin bad++; $display("[TB] FAIL ack_redirect got=%b/%b/%h exp=0/1/500", inst_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    imem_ack = 1; imem_rdata = $urandom;
    tick();
    imem_ack = 0;
    redirect_valid = 1; redirect_target = 32'h200; inst_ready = 1;
    tick();
    redirect_valid = 0; inst_ready = 0;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("[TB] FAIL hold_redirect got=%b/%b/%h exp=0/1/200", inst_valid, imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = $urandom;
    tick();
    imem_ack = 0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin bad++; $display("[TB] FAIL hold_inst got=%b/%h exp=1/200", inst_valid, inst_pc); end
    redirect_valid = 1; redirect_target = 32'h280;
    tick();
    redirect_valid = 0;
    total++; if (inst_valid !== 1'b0 || imem_addr !== 32'h280) begin bad++; $display("[TB] FAIL hold_noready got=%b/%h exp=0/280", inst_valid, imem_addr); end
    rst = 1;
    tick();
    rst = 0; redirect_valid = 1; redirect_target = 32'h400;
    tick();
    redirect_valid = 0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || pc_out !== 32'h400) begin bad++; $display("[TB] FAIL idle_redirect got=%b/%h/%h exp=1/400/400", imem_req, imem_addr, pc_out); end
  endtask

  task automatic test_misalign();
    do_reset();
    redirect_valid = 1; redirect_target = 32'h102;
    tick();
    redirect_valid = 0;
    total++; if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL err_req got=%b/%b exp=1/0", misalign_err, imem_req); end
    do_reset();
    total++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_first got=%b/%h exp=1/fffffffc", w_imem_req, w_imem_addr); end
    w_imem_ack = 1; w_imem_rdata = $urandom;
    tick();
    w_imem_ack = 0;
    total++; if (w_inst_pc !== 32'hFFFF_FFFC || w_pc_out !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc got=%h/%h exp=fffffffc/0", w_inst_pc, w_pc_out); end
    w_inst_ready = 1;
    tick();
    w_inst_ready = 0;
    total++; if (w_imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_second got=%h exp=0", w_imem_addr); end
    w_imem_ack = 1;
    tick();
    w_imem_ack = 0;
    w_redirect_valid = 1; w_redirect_target = 32'h102;
    tick();
    total++; if (w_misalign_err !== 1'b1 || w_imem_req !== 1'b0 || w_inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_err got=%b/%b/%b exp=1/0/0", w_misalign_err, w_imem_req, w_inst_valid); end
    for (int k = 0; k < 4; k++) begin
      w_redirect_target = 32'h40 * (k + 1); w_imem_ack = 1; w_inst_ready = 1;
      tick();
      total++; if (w_misalign_err !== 1'b1 || w_imem_req !== 1'b0) begin bad++; $display("[TB] FAIL err_sticky got=%b/%b exp=1/0", w_misalign_err, w_imem_req); end
    end
    idle_inputs();
    rst = 1;
    #1;
    total++; if (w_misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL err_clear got=%b exp=0", w_misalign_err); end
    tick();
    rst = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    redirect_valid = 1; redirect_target = 32'h100;
    tick();
    redirect_valid = 0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL areset_drain got=%b/%h exp=1/0", imem_req, imem_addr); end
    #3;
    rst = 1;
    #1;
    total++; if (imem_req !== 1'b0 || pc_out !== 32'h0 || inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_now got=%b/%h/%b exp=0/0/0", imem_req, pc_out, inst_valid); end
    imem_ack = 1; imem_rdata = $urandom;
    tick();
    imem_ack = 0;
    tick();
    rst = 0;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL areset_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 0;
    total++; if (inst_pc !== 32'h0 || inst_out !== 32'h1234_5678) begin bad++; $display("[TB] FAIL areset_inst got=%h/%h exp=0/12345678", inst_pc, inst_out); end
  endtask

  initial begin
    idle_inputs();
    $display("[TB] starting fetch_controller bench");
    test_reset();
    test_basic();
    test_random_handshake();
    test_redirect_drain();
    test_redirect_hold();
    test_misalign();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
